// File: rtl/i2c_target.sv
// I2C target with a fixed 7-bit address. Inputs are synchronized and glitch filtered.
// Bytes move through valid/ready streams, and SCL is stretched while a stream is waiting.
module i2c_target #(
  parameter logic [6:0] ADDRESS    = 7'h2F,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       i2c_write,
  output logic       i2c_read,
  output logic [7:0] i2c_write_data,
  output logic       i2c_write_valid,
  input  logic       i2c_write_ready,
  output logic       i2c_read_ready,
  input  logic [7:0] i2c_read_data,
  input  logic       i2c_read_valid
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_WAIT, WR_ACK, RD_WAIT, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  logic [1:0]            scl_sync, sda_sync;
  logic [FILTER_LEN-1:0] scl_hist, sda_hist;
  logic                  scl_f, sda_f, scl_prev, sda_prev;

  // A new level is accepted only after FILTER_LEN identical synchronized samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= FILTER_LEN'({scl_hist, scl_sync[1]});
      sda_hist <= FILTER_LEN'({sda_hist, sda_sync[1]});
      if (&scl_hist)       scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)       sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_prev;
  assign scl_fall  = ~scl_f & scl_prev;
  assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [6:0] tx, tx_n;
  logic       rw, rw_n, ack_ok, ack_ok_n;
  logic       scl_oe_n, sda_oe_n, i2c_write_n, i2c_read_n;
  logic [7:0] write_data_n;
  logic       write_valid_n, read_ready_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bit_cnt         <= 4'd0;
      shift           <= 8'd0;
      tx              <= 7'd0;
      rw              <= 1'b0;
      ack_ok          <= 1'b0;
      scl_oe          <= 1'b0;
      sda_oe          <= 1'b0;
      i2c_write       <= 1'b0;
      i2c_read        <= 1'b0;
      i2c_write_data  <= 8'd0;
      i2c_write_valid <= 1'b0;
      i2c_read_ready  <= 1'b0;
    end else begin
      state           <= state_n;
      bit_cnt         <= bit_cnt_n;
      shift           <= shift_n;
      tx              <= tx_n;
      rw              <= rw_n;
      ack_ok          <= ack_ok_n;
      scl_oe          <= scl_oe_n;
      sda_oe          <= sda_oe_n;
      i2c_write       <= i2c_write_n;
      i2c_read        <= i2c_read_n;
      i2c_write_data  <= write_data_n;
      i2c_write_valid <= write_valid_n;
      i2c_read_ready  <= read_ready_n;
    end
  end

  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    shift_n       = shift;
    tx_n          = tx;
    rw_n          = rw;
    ack_ok_n      = ack_ok;
    scl_oe_n      = scl_oe;
    sda_oe_n      = sda_oe;
    i2c_write_n   = 1'b0;
    i2c_read_n    = 1'b0;
    write_data_n  = i2c_write_data;
    write_valid_n = i2c_write_valid;
    read_ready_n  = i2c_read_ready;

    // Bus conditions override bit handling and abandon any pending handshake.
    if (start_det || stop_det) begin
      state_n       = start_det ? ADDR : IDLE;
      bit_cnt_n     = 4'd0;
      ack_ok_n      = 1'b0;
      scl_oe_n      = 1'b0;
      sda_oe_n      = 1'b0;
      write_valid_n = 1'b0;
      read_ready_n  = 1'b0;
    end else begin
      case (state)
        ADDR, WR_BYTE: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_n   = {shift[6:0], sda_f};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd0;
            if (state == WR_BYTE) begin
              write_data_n  = shift;
              write_valid_n = 1'b1;
              scl_oe_n      = 1'b1;
              state_n       = WR_WAIT;
            end else if (shift[7:1] == ADDRESS) begin
              rw_n        = shift[0];
              sda_oe_n    = 1'b1;
              i2c_write_n = ~shift[0];
              i2c_read_n  = shift[0];
              state_n     = ADDR_ACK;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            if (rw) begin
              read_ready_n = 1'b1;
              scl_oe_n     = 1'b1;
              state_n      = RD_WAIT;
            end else begin
              state_n = WR_BYTE;
            end
          end
        end
        WR_WAIT: begin
          if (i2c_write_ready) begin
            write_valid_n = 1'b0;
            sda_oe_n      = 1'b1;
            scl_oe_n      = 1'b0;
            bit_cnt_n     = 4'd0;
            state_n       = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = WR_BYTE;
          end
        end
        RD_WAIT: begin
          if (i2c_read_valid) begin
            tx_n         = i2c_read_data[6:0];
            sda_oe_n     = ~i2c_read_data[7];
            read_ready_n = 1'b0;
            scl_oe_n     = 1'b0;
            bit_cnt_n    = 4'd0;
            state_n      = RD_BYTE;
          end
        end
        RD_BYTE: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
            state_n   = RD_ACK;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            sda_oe_n = ~tx[6];
            tx_n     = {tx[5:0], 1'b0};
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_f) state_n  = IGNORE;
            else       ack_ok_n = 1'b1;
          end else if (scl_fall && ack_ok) begin
            ack_ok_n     = 1'b0;
            read_ready_n = 1'b1;
            scl_oe_n     = 1'b1;
            state_n      = RD_WAIT;
          end
        end
        IDLE, IGNORE: ;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged master on a wired-AND bus,
// combinational read responder, and a negedge monitor for pulses and streams.
module tb_i2c_target;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1, scl_g = 1'b0, sda_g = 1'b0;
  logic       scl_in, sda_in, scl_oe, sda_oe, i2c_write, i2c_read;
  logic [7:0] i2c_write_data, i2c_read_data;
  logic       i2c_write_valid, i2c_read_ready, i2c_read_valid;
  logic       wr_ready = 1'b1, rd_en = 1'b1;
  logic       scl_bus, sda_bus;
  logic [7:0] rd_bytes [16];
  logic [3:0] rd_idx = 4'd0;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign scl_bus        = scl_m & ~scl_oe;
  assign sda_bus        = sda_m & ~sda_oe;
  assign scl_in         = scl_bus ^ scl_g;
  assign sda_in         = sda_bus ^ sda_g;
  assign i2c_read_valid = rd_en & i2c_read_ready;
  assign i2c_read_data  = rd_bytes[rd_idx];

  i2c_target dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .i2c_write(i2c_write), .i2c_read(i2c_read),
    .i2c_write_data(i2c_write_data), .i2c_write_valid(i2c_write_valid),
    .i2c_write_ready(wr_ready), .i2c_read_ready(i2c_read_ready),
    .i2c_read_data(i2c_read_data), .i2c_read_valid(i2c_read_valid)
  );

  always @(posedge clk) if (i2c_read_ready && i2c_read_valid) rd_idx <= rd_idx + 4'd1;

  int         cyc = 0, wr_pulses = 0, rd_pulses = 0, pulse_err = 0, unstable = 0;
  int         rr_rises = 0, oe_seen = 0, last_wr_cyc = -1, last_rd_cyc = -1, ready_gap = -1;
  bit         pend = 1'b0, prev_w = 1'b0, prev_r = 1'b0, prev_valid = 1'b0, prev_xfer = 1'b0, prev_rr = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] wq [$];

  always @(negedge clk) begin
    cyc++;
    if (i2c_write) begin wr_pulses++; last_wr_cyc = cyc; end
    if (i2c_read) begin rd_pulses++; last_rd_cyc = cyc; pend = 1'b1; end
    if (i2c_write && i2c_read) pulse_err++;
    if ((i2c_write && prev_w) || (i2c_read && prev_r)) pulse_err++;
    if (i2c_write_valid && wr_ready) wq.push_back(i2c_write_data);
    if (i2c_write_valid && prev_valid && !prev_xfer && i2c_write_data != prev_data) unstable++;
    if (i2c_read_ready && !prev_rr) begin
      rr_rises++;
      if (pend) begin ready_gap = cyc - last_rd_cyc; pend = 1'b0; end
    end
    if (scl_oe || sda_oe) oe_seen++;
    prev_w = i2c_write; prev_r = i2c_read; prev_rr = i2c_read_ready;
    prev_valid = i2c_write_valid; prev_xfer = i2c_write_valid && wr_ready;
    prev_data = i2c_write_data;
  end

  int b_wr, b_rd, b_err, b_q, b_rr, b_oe, b_uns;

  task automatic snap();
    b_wr = wr_pulses; b_rd = rd_pulses; b_err = pulse_err; b_q = wq.size();
    b_rr = rr_rises; b_oe = oe_seen; b_uns = unstable;
  endtask

  function automatic int qat(input int i);
    return (i < wq.size()) ? int'(wq[i]) : -1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_scl_high();
    int k = 0;
    while (scl_bus !== 1'b1 && k < 4000) begin tick(1); k++; end
    if (k >= 4000) checkOutput("scl_release_timeout", 0, 1);
  endtask

  // One SCL period: data changes in the low phase, optional glitches in either phase.
  task automatic clock_bit(input logic b, input bit g_scl, input bit g_sda, output logic s);
    tick(4);
    sda_m = b;
    if (g_scl) begin tick(2); scl_g = 1'b1; tick(1); scl_g = 1'b0; tick(5); end
    else tick(H);
    scl_m = 1'b1;
    wait_scl_high();
    tick(4);
    s = sda_bus;
    if (g_sda) begin sda_g = 1'b1; tick(2); sda_g = 1'b0; tick(2); end
    else tick(4);
    scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int g_scl_bit, input int g_sda_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], i == g_scl_bit, i == g_sda_bit, s);
    clock_bit(1'b1, 1'b0, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin clock_bit(1'b1, 1'b0, 1'b0, s); b[i] = s; end
    clock_bit(~ack, 1'b0, 1'b0, s);
  endtask

  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      tick(4); sda_m = 1'b1; tick(H); scl_m = 1'b1; wait_scl_high(); tick(H);
    end
    sda_m = 1'b0; tick(H); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(4); sda_m = 1'b0; tick(H); scl_m = 1'b1; wait_scl_high(); tick(H);
    sda_m = 1'b1; tick(12);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } vec_t;

  task automatic applyStimulus(input vec_t v, output logic a, output logic a0, output logic a1);
    snap();
    i2c_start();
    send_byte(v.addr, -1, -1, a);
    send_byte(v.d0, -1, -1, a0);
    send_byte(v.d1, -1, -1, a1);
    i2c_stop();
    tick(20);
  endtask

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t       vecs [6];
    logic       a, a0, a1, a2;
    logic [7:0] r0, r1;
    int         stall_bad, early, k;

    vecs[0] = '{8'h5E, 8'hA5, 8'h3C, 1'b1};
    vecs[1] = '{8'h5A, 8'h12, 8'h34, 1'b0};
    vecs[2] = '{8'h5E, 8'hFF, 8'h00, 1'b1};
    vecs[3] = '{8'h5C, 8'h55, 8'hAA, 1'b0};
    vecs[4] = '{8'hDE, 8'h5E, 8'h00, 1'b0};
    vecs[5] = '{8'h5E, 8'h80, 8'h01, 1'b1};
    for (int i = 0; i < 16; i++) rd_bytes[i] = 8'h00;
    rd_bytes[0] = 8'h80; rd_bytes[1] = 8'h11; rd_bytes[2] = 8'h5A;

    tick(5);
    checkOutput("reset_lines", {scl_oe, sda_oe}, 0);
    checkOutput("reset_pulses", {i2c_write, i2c_read}, 0);
    checkOutput("reset_handshake", {i2c_write_valid, i2c_read_ready}, 0);
    rst = 1'b0;
    tick(20);

    for (int n = 0; n < 6; n++) begin
      applyStimulus(vecs[n], a, a0, a1);
      checkOutput($sformatf("v%0d_addr_ack", n), a, vecs[n].exp_ack);
      checkOutput($sformatf("v%0d_wr_pulses", n), wr_pulses - b_wr, vecs[n].exp_ack);
      checkOutput($sformatf("v%0d_rd_pulses", n), rd_pulses - b_rd, 0);
      checkOutput($sformatf("v%0d_bytes", n), wq.size() - b_q, vecs[n].exp_ack ? 2 : 0);
      if (vecs[n].exp_ack) begin
        checkOutput($sformatf("v%0d_d0_ack", n), a0, 1);
        checkOutput($sformatf("v%0d_d1_ack", n), a1, 1);
        checkOutput($sformatf("v%0d_d0", n), qat(b_q), vecs[n].d0);
        checkOutput($sformatf("v%0d_d1", n), qat(b_q + 1), vecs[n].d1);
      end else begin
        checkOutput($sformatf("v%0d_oe_cycles", n), oe_seen - b_oe, 0);
      end
      checkOutput($sformatf("v%0d_pulse_err", n), pulse_err - b_err, 0);
    end

    // Write with byte 2 held off by write_ready for 50 cycles.
    snap();
    i2c_start();
    send_byte(8'h5E, -1, -1, a);
    send_byte(8'hA5, -1, -1, a0);
    wr_ready = 1'b0;
    stall_bad = 0;
    early = -1;
    fork
      send_byte(8'h3C, -1, -1, a1);
      begin
        k = 0;
        while (!i2c_write_valid && k < 1000) begin tick(1); k++; end
        checkOutput("stall_valid_seen", int'(k < 1000), 1);
        for (int j = 0; j < 50; j++) begin
          tick(1);
          if (!scl_oe || !i2c_write_valid || scl_bus) stall_bad++;
        end
        early = wq.size() - b_q;
        wr_ready = 1'b1;
      end
    join
    i2c_stop();
    tick(20);
    checkOutput("stall_scl_held", stall_bad, 0);
    checkOutput("stall_bytes_before_ready", early, 1);
    checkOutput("stall_d1_ack", a1, 1);
    checkOutput("stall_bytes", wq.size() - b_q, 2);
    checkOutput("stall_d1", qat(b_q + 1), 8'h3C);
    checkOutput("stall_data_stable", unstable - b_uns, 0);

    // Read two bytes, ACK the first and NACK the second.
    snap();
    i2c_start();
    send_byte(8'h5F, -1, -1, a);
    read_byte(r0, 1'b1);
    read_byte(r1, 1'b0);
    i2c_stop();
    tick(20);
    checkOutput("rd_addr_ack", a, 1);
    checkOutput("rd_byte0", r0, 8'h80);
    checkOutput("rd_byte1", r1, 8'h11);
    checkOutput("rd_pulses", rd_pulses - b_rd, 1);
    checkOutput("rd_wr_pulses", wr_pulses - b_wr, 0);
    checkOutput("rd_ready_count", rr_rises - b_rr, 2);
    checkOutput("rd_ready_after_pulse", int'(ready_gap >= 1), 1);

    // Write then repeated START into a read.
    snap();
    i2c_start();
    send_byte(8'h5E, -1, -1, a);
    send_byte(8'h01, -1, -1, a0);
    i2c_start();
    send_byte(8'h5F, -1, -1, a1);
    read_byte(r0, 1'b0);
    i2c_stop();
    tick(20);
    checkOutput("rs_acks", {a, a0, a1}, 3'b111);
    checkOutput("rs_wr_byte", qat(b_q), 8'h01);
    checkOutput("rs_pulses", (wr_pulses - b_wr) * 16 + (rd_pulses - b_rd), 8'h11);
    checkOutput("rs_pulse_order", int'(last_wr_cyc < last_rd_cyc), 1);
    checkOutput("rs_rd_byte", r0, 8'h5A);
    checkOutput("rs_pulse_err", pulse_err - b_err, 0);

    // Glitches: a short SDA dip at idle must not open a transaction.
    snap();
    tick(10); sda_g = 1'b1; tick(1); sda_g = 1'b0; tick(20);
    send_byte(8'h5E, -1, -1, a);
    i2c_stop();
    checkOutput("gl_false_start_ack", a, 0);
    checkOutput("gl_false_start_pulses", wr_pulses - b_wr, 0);
    snap();
    i2c_start();
    send_byte(8'h5E, 6, -1, a);
    send_byte(8'hA5, -1, 2, a0);
    i2c_stop();
    tick(20);
    checkOutput("gl_scl_glitch_ack", a, 1);
    checkOutput("gl_sda_glitch_ack", a0, 1);
    checkOutput("gl_wr_byte", qat(b_q), 8'hA5);
    checkOutput("gl_wr_pulses", wr_pulses - b_wr, 1);

    // Reset while stretching in RD_WAIT.
    snap();
    rd_en = 1'b0;
    i2c_start();
    send_byte(8'h5F, -1, -1, a);
    k = 0;
    while (!i2c_read_ready && k < 200) begin tick(1); k++; end
    scl_m = 1'b1;
    tick(3);
    checkOutput("rst_pre_ready", i2c_read_ready, 1);
    checkOutput("rst_pre_stretch", {scl_oe, scl_bus}, 2'b10);
    rst = 1'b1;
    tick(1);
    checkOutput("rst_lines", {scl_oe, sda_oe}, 0);
    checkOutput("rst_ready", i2c_read_ready, 0);
    rst = 1'b0;
    rd_en = 1'b1;
    tick(30);
    send_byte(8'h5F, -1, -1, a2);
    i2c_stop();
    checkOutput("rst_needs_start", a2, 0);
    checkOutput("rst_rd_pulses", rd_pulses - b_rd, 1);
    snap();
    i2c_start();
    send_byte(8'h5E, -1, -1, a);
    send_byte(8'h77, -1, -1, a0);
    i2c_stop();
    tick(20);
    checkOutput("rst_recover_acks", {a, a0}, 2'b11);
    checkOutput("rst_recover_byte", qat(b_q), 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
